// File: rtl/store_pkg.sv
// rtl/store_pkg.sv - op encodings, FSM states and size/alignment helpers for the store path
package store_pkg;

  typedef enum logic [1:0] {
    OP_SB = 2'b00,
    OP_SH = 2'b01,
    OP_SW = 2'b10,
    OP_SD = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_WRITE,
    ST_ERR
  } state_e;

  function automatic logic [3:0] op_bytes(op_e op);
    case (op)
      OP_SB:   return 4'd1;
      OP_SH:   return 4'd2;
      OP_SW:   return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  // Offset is zero-extended to 3 bits so one helper serves both word widths.
  function automatic logic misaligned(op_e op, logic [2:0] offset, int xlen);
    case (op)
      OP_SB:   return 1'b0;
      OP_SH:   return offset[0];
      OP_SW:   return offset[1:0] != 2'b00;
      default: return (xlen != 64) || (offset != 3'b000);
    endcase
  endfunction

endpackage

// File: rtl/store_rmw_unit_if.sv
// rtl/store_rmw_unit_if.sv - request handshake and data-memory bus of the store unit
interface store_rmw_unit_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  import store_pkg::*;

  logic              req_valid;
  logic              req_ready;
  op_e               req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_data;
  logic              done;
  logic              err;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_valid;
  logic [XLEN-1:0]   mem_rd_data;
  logic              mem_wr_en;
  logic [XLEN-1:0]   mem_wr_data;

  modport master (
    output req_valid, req_op, req_addr, req_data, mem_rd_valid, mem_rd_data,
    input  req_ready, done, err, mem_rd_en, mem_addr, mem_wr_en, mem_wr_data
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_data, mem_rd_valid, mem_rd_data,
    output req_ready, done, err, mem_rd_en, mem_addr, mem_wr_en, mem_wr_data
  );

endinterface

// File: rtl/store_merge.sv
// rtl/store_merge.sv - combinational byte-lane merge of store data into a memory word
module store_merge
  import store_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OFF_W = $clog2(XLEN/8)
) (
  input  logic [XLEN-1:0]  old_word,
  input  logic [XLEN-1:0]  store_data,
  input  op_e              op,
  input  logic [OFF_W-1:0] offset,
  output logic [XLEN-1:0]  merged
);

  localparam int NB = XLEN / 8;

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted = store_data << {offset, 3'b000};
    merged  = old_word;
    for (int i = 0; i < NB; i++) begin
      if ((i >= int'(offset)) && (i < int'(offset) + int'(op_bytes(op)))) begin
        merged[8*i +: 8] = shifted[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/store_rmw_unit.sv
// rtl/store_rmw_unit.sv - multi-cycle store path with read-modify-write for sub-word stores
module store_rmw_unit
  import store_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic clk,
  input  logic rst,
  store_rmw_unit_if.slave bus
);

  localparam int OFF_W = $clog2(XLEN/8);
  localparam int NB    = XLEN / 8;

  state_e            state_q, state_d;
  op_e               op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   data_q;
  logic [OFF_W-1:0]  off_q;
  logic [XLEN-1:0]   wr_data_q;
  logic [XLEN-1:0]   merged;

  logic [OFF_W-1:0]  req_off;
  logic              accept;
  logic              illegal;
  logic              full;

  assign req_off = bus.req_addr[OFF_W-1:0];
  assign accept  = (state_q == ST_IDLE) && bus.req_valid;
  assign illegal = misaligned(bus.req_op, 3'(req_off), XLEN);
  assign full    = (op_bytes(bus.req_op) == 4'(NB));

  store_merge #(.XLEN(XLEN)) u_merge (
    .old_word   (bus.mem_rd_data),
    .store_data (data_q),
    .op         (op_q),
    .offset     (off_q),
    .merged     (merged)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (illegal)   state_d = ST_ERR;
          else if (full) state_d = ST_WRITE;
          else           state_d = ST_READ;
        end
      end
      ST_READ:  state_d = ST_WAIT;
      ST_WAIT:  if (bus.mem_rd_valid) state_d = ST_WRITE;
      ST_WRITE: state_d = ST_IDLE;
      ST_ERR:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= OP_SB;
      addr_q    <= '0;
      data_q    <= '0;
      off_q     <= '0;
      wr_data_q <= '0;
    end else if (accept) begin
      op_q   <= bus.req_op;
      addr_q <= {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      data_q <= bus.req_data;
      off_q  <= req_off;
      if (!illegal && full) wr_data_q <= bus.req_data;
    end else if ((state_q == ST_WAIT) && bus.mem_rd_valid) begin
      wr_data_q <= merged;
    end
  end

  assign bus.req_ready   = (state_q == ST_IDLE);
  assign bus.mem_rd_en   = (state_q == ST_READ);
  assign bus.mem_wr_en   = (state_q == ST_WRITE);
  assign bus.done        = (state_q == ST_WRITE);
  assign bus.err         = (state_q == ST_ERR);
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wr_data = wr_data_q;

endmodule

// File: doc/store_rmw_unit.md
Name: store_rmw_unit

Overview:
- Parametrised, multi-cycle store path for the data memory.
- Accepts a store request (byte, half, word or, at XLEN=64, double) with a byte address.
- Sub-word stores run a read-modify-write: read the containing memory word, merge the store lanes in, write it back.
- Full-width stores skip the read. Misaligned or illegal stores are rejected with an error pulse and no memory write.

Parameters:
- XLEN, 32, data and memory word width in bits; legal values 32 or 64.
- ADDR_W, 32, byte-address width.
- OFF_W, $clog2(XLEN/8), derived; byte-offset bits within a memory word.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  store request present
- req_ready  out  1  unit can accept a request
- req_op  in  2  00 sb, 01 sh, 10 sw, 11 sd
- req_addr  in  ADDR_W  byte address
- req_data  in  XLEN  store data, right-aligned (rs2 value)
- done  out  1  one-cycle pulse, store committed
- err  out  1  one-cycle pulse, store rejected
- mem_rd_en  out  1  memory read strobe
- mem_addr  out  ADDR_W  word-aligned address: req_addr with low OFF_W bits zero
- mem_rd_valid  in  1  read data valid
- mem_rd_data  in  XLEN  read data
- mem_wr_en  out  1  memory write strobe
- mem_wr_data  out  XLEN  merged word to write

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE; req_ready=1.
  - done, err, mem_rd_en and mem_wr_en are 0; mem_addr and mem_wr_data are 0.
  - Reset mid-operation aborts the store: no write is issued and mem_rd_valid is ignored.
- States: IDLE, READ, WAIT, WRITE, ERR.
- IDLE:
  - req_ready=1, the only state where it is 1.
  - On req_valid, latch op, address, data and offset = req_addr[OFF_W-1:0].
  - If the request is illegal, go to ERR.
  - Else if op size equals XLEN/8 bytes, load mem_wr_data=req_data and go to WRITE.
  - Otherwise go to READ.
- Illegal requests:
  - sh with addr[0]=1.
  - sw with addr[1:0]!=0.
  - sd with XLEN=32.
  - sd with addr[2:0]!=0.
- READ: mem_rd_en=1 for exactly one cycle, mem_addr valid; next state WAIT.
- WAIT:
  - Hold until mem_rd_valid=1.
  - On that cycle, register the merged word into mem_wr_data, then go to WRITE.
  - mem_rd_valid is ignored in every other state.
- Merge rule: byte lane i (i = 0..XLEN/8-1) takes req_data's byte (i - offset) when offset ≤ i < offset + size. Otherwise lane i takes mem_rd_data byte i (little-endian).
- WRITE: mem_wr_en=1 and done=1 for one cycle, mem_addr held; next state IDLE.
- ERR: err=1 for one cycle; no mem_rd_en or mem_wr_en; next state IDLE.
- Latency, with the request accepted at cycle T:
  - Full-width store: write and done at T+1.
  - Sub-word store: read at T+1; write and done one cycle after the mem_rd_valid cycle. Minimum T+3 when valid arrives at T+2.
  - Error: err at T+1.
- Back-to-back: the next request can be accepted on the cycle after done or err, when the state is IDLE again. No overlap, so there are no read-after-write hazards inside the unit.
- mem_addr holds its value from acceptance until the next acceptance. mem_wr_data changes only on merge or on a full-width load.

Decomposition:
- Package store_pkg:
  - op encodings OP_SB/OP_SH/OP_SW/OP_SD.
  - State enum.
  - Function op_bytes(op) returning 1/2/4/8.
  - Function misaligned(op, offset, XLEN).
- Sub-module store_merge (combinational, parametrised by XLEN):
  - Inputs: old word, store data, op, offset.
  - Output: merged word.
  - The XLEN=32 instance replaces the fixed 32-bit merge logic.

Test Plan:
- XLEN=32, sb:
  - Stimulus: addr=0x1003, data=0x000000AB, memory returns 0x11223344.
  - Expected: mem_addr=0x1000, one read, mem_wr_data=0xAB223344, done once.
- XLEN=32, sh:
  - Stimulus: addr=0x0006, data=0xFFFFBEEF, memory returns 0xCAFEF00D.
  - Expected: mem_wr_data=0xBEEFF00D.
  - Stimulus: sh to 0x0005.
  - Expected: err at T+1, no mem_rd_en or mem_wr_en.
- XLEN=32, sw:
  - Stimulus: addr=0x0008, data=0xDEADBEEF.
  - Expected: no read; mem_wr_en and done at T+1 with 0xDEADBEEF.
  - Stimulus: sd.
  - Expected: err.
- XLEN=64, sh:
  - Stimulus: addr=0x0A, data=0x1234, memory returns 0x0011223344556677.
  - Expected: mem_addr=0x08, mem_wr_data=0x0011223312346677.
  - Stimulus: sd to 0x10.
  - Expected: direct write.
- Memory stall and reset:
  - Stimulus: sb with mem_rd_valid delayed 5 cycles.
  - Expected: req_ready=0 and no write until valid, write on the following cycle.
  - Stimulus: repeat with rst asserted during WAIT.
  - Expected: no mem_wr_en, IDLE next cycle, a late valid ignored.
- Back-to-back:
  - Stimulus: sw then sb issued with req_valid held high.
  - Expected: second request accepted the cycle after the first done; the two writes are in order.
